// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray code helpers and receiver state type
package gray_pkg;

    // Default Gray bus width shared by the LED transmitter and receiver designs
    localparam int GRAY_W = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        TRACK    = 1'b1
    } rx_state_t;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_rx_filter.sv
// rtl/gray_rx_filter.sv - two-flop synchroniser and stability filter for the Gray bus
module gray_rx_filter
    import gray_pkg::*;
#(
    parameter int BITS          = GRAY_W,
    parameter int STABLE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [BITS-1:0] gray_in,
    input  logic [BITS-1:0] acc,
    input  logic            locked,
    output logic [BITS-1:0] cand,
    output logic            accept
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [BITS-1:0]  s1;
    logic [BITS-1:0]  s2;
    logic [CNT_W-1:0] cnt;

    // Synchronise the pins, then restart the run count whenever the sample moves
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
        end else begin
            s1 <= gray_in;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A settled code is offered once; after lock only codes differing from the accepted one
    assign accept = (s2 == cand) && (cnt == CNT_MAX) && (!locked || (cand != acc));

endmodule

// File: rtl/gray_led_rx.sv
// rtl/gray_led_rx.sv - Gray LED counter receiver: decode, classify steps, count glitches
module gray_led_rx
    import gray_pkg::*;
#(
    parameter int BITS          = GRAY_W,
    parameter int STABLE_CYCLES = 16,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [BITS-1:0]  gray_in,
    output logic [BITS-1:0]  value,
    output logic             value_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             glitch,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    rx_state_t       state;
    rx_state_t       state_next;
    logic [BITS-1:0] cand;
    logic [BITS-1:0] acc;
    logic            accept;
    logic [BITS-1:0] nv;
    logic [BITS-1:0] ov_inc;
    logic [BITS-1:0] ov_dec;
    logic            is_up;
    logic            is_down;
    logic            classify;

    gray_rx_filter #(
        .BITS          (BITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .resetn  (resetn),
        .gray_in (gray_in),
        .acc     (acc),
        .locked  (locked),
        .cand    (cand),
        .accept  (accept)
    );

    assign locked = (state == TRACK);

    // State register: once tracking, only reset returns to UNLOCKED
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Next state and step classification of the candidate against the last value
    always_comb begin
        state_next = state;
        nv         = gray2bin(cand);
        ov_inc     = value + 1'b1;
        ov_dec     = value - 1'b1;
        is_up      = (nv == ov_inc);
        is_down    = (nv == ov_dec) && !is_up;
        classify   = accept && (state == TRACK);
        if (state == UNLOCKED && accept) begin
            state_next = TRACK;
        end
    end

    // Registered accept outputs: value update, one-cycle pulses and saturating glitch count
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            glitch      <= 1'b0;
            err_count   <= '0;
        end else begin
            value_valid <= accept;
            step_up     <= classify && is_up;
            step_down   <= classify && is_down;
            glitch      <= classify && !is_up && !is_down;
            if (accept) begin
                acc   <= cand;
                value <= nv;
            end
            if (classify && !is_up && !is_down && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_led_rx.sv
// tb/tb_gray_led_rx.sv - scoreboard bench for gray_led_rx with STABLE_CYCLES=4
module tb_gray_led_rx;

    localparam int SC = 4;
    localparam int EW = 3;

    typedef struct {
        logic [3:0]    v;
        logic          up;
        logic          dn;
        logic          gl;
        logic [EW-1:0] err;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [3:0]    gray_in = 4'b0000;
    logic [3:0]    value;
    logic          value_valid;
    logic          step_up;
    logic          step_down;
    logic          glitch;
    logic          locked;
    logic [EW-1:0] err_count;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    exp_t          sb[$];
    logic [3:0]    m_val = 4'd0;
    logic          m_locked = 1'b0;
    logic [EW-1:0] m_err = '0;

    always #5 clk = ~clk;

    gray_led_rx #(
        .BITS          (4),
        .STABLE_CYCLES (SC),
        .ERR_W         (EW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .gray_in     (gray_in),
        .value       (value),
        .value_valid (value_valid),
        .step_up     (step_up),
        .step_down   (step_down),
        .glitch      (glitch),
        .locked      (locked),
        .err_count   (err_count)
    );

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_code(input logic [3:0] code);
        exp_t       e;
        logic [3:0] nv;
        logic [3:0] inc;
        logic [3:0] dec;
        nv  = g2b(code);
        inc = m_val + 4'd1;
        dec = m_val - 4'd1;
        e.v  = nv;
        e.up = m_locked && (nv == inc);
        e.dn = m_locked && (nv == dec);
        e.gl = m_locked && !e.up && !e.dn;
        if (e.gl && m_err != '1) m_err = m_err + 1'b1;
        e.err    = m_err;
        m_val    = nv;
        m_locked = 1'b1;
        sb.push_back(e);
    endtask

    task automatic apply(input logic [3:0] code);
        push_code(code);
        @(posedge clk); #1 gray_in = code;
        repeat (10) @(posedge clk);
        #1 check("drained", sb.size(), 0);
    endtask

    task automatic check_reset_state();
        check("rst_value", value, 0);
        check("rst_pulses", {value_valid, step_up, step_down, glitch}, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err_count, 0);
    endtask

    // Scoreboard monitor: every value_valid pops one expectation; pulses outside it are stray
    always @(negedge clk) begin
        if (resetn) begin
            if (value_valid) begin
                check("expected_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("value", value, e.v);
                    check("step_up", step_up, e.up);
                    check("step_down", step_down, e.dn);
                    check("glitch", glitch, e.gl);
                    check("locked", locked, 1);
                    check("err_count", err_count, e.err);
                end
            end else begin
                check("stray_pulse", {step_up, step_down, glitch}, 0);
            end
        end
    end

    initial begin
        int  n;
        bit  seen;

        // Reset and lock on 0000
        repeat (3) @(posedge clk);
        #1 check_reset_state();
        push_code(4'b0000);
        resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1 check("lock_drained", sb.size(), 0);
        check("locked_after_first", locked, 1);

        // Latency of the first step
        push_code(4'b0001);
        @(posedge clk); #1 gray_in = 4'b0001;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); n++;
            #1 if (value_valid) seen = 1;
        end
        check("latency_edges", n, SC + 3);
        repeat (4) @(posedge clk);
        #1 check("latency_drained", sb.size(), 0);

        // Walk the remaining codes up and wrap to 0
        for (int i = 2; i < 16; i++) apply(b2g(4'(i)));
        apply(4'b0000);
        check("walk_err", err_count, 0);

        // Step down 2 -> 1 -> 0
        apply(b2g(4'd1));
        apply(b2g(4'd2));
        apply(4'b0001);
        apply(4'b0000);
        check("down_value", value, 0);

        // One-bit Gray change between non-adjacent values
        apply(4'b0001);
        apply(4'b1001);
        check("glitch_value", value, 14);
        check("glitch_err", err_count, 1);

        // Bounce bit0 every 2 cycles for 20 cycles, then settle on 1000
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1 gray_in = gray_in ^ 4'b0001;
            repeat (2) @(posedge clk);
        end
        #1 check("bounce_silent", sb.size(), 0);
        push_code(4'b1000);
        gray_in = 4'b1000;
        repeat (12) @(posedge clk);
        #1 check("bounce_drained", sb.size(), 0);

        // Two-bit jump 0000 -> 0011
        apply(4'b0000);
        apply(4'b0011);
        check("jump_value", value, 2);

        // Input changes on the accept edge: both codes accepted
        push_code(4'b0010);
        push_code(4'b0110);
        @(posedge clk); #1 gray_in = 4'b0010;
        repeat (5) @(posedge clk);
        #1 gray_in = 4'b0110;
        repeat (14) @(posedge clk);
        #1 check("edge_change_drained", sb.size(), 0);
        check("edge_change_value", value, 4);

        // Glitch counter saturation
        for (int k = 0; k < 6; k++) apply((k % 2 == 0) ? 4'b0011 : 4'b0000);
        check("err_saturated", err_count, 3'd7);

        // Reset for one cycle mid-filter, then re-lock without classification
        @(posedge clk); #1 gray_in = 4'b0001;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 check_reset_state();
        sb.delete();
        m_locked = 1'b0;
        m_err    = '0;
        m_val    = 4'd0;
        push_code(4'b0001);
        resetn = 1'b1;
        repeat (14) @(posedge clk);
        #1 check("relock_drained", sb.size(), 0);
        check("relock_value", value, 1);
        check("relock_locked", locked, 1);
        check("relock_err", err_count, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
